llc_rr_arbiter: RTL
===================

// Module: llc_rr_arbiter
//
// PURPOSE
//   Round-robin arbiter with grant lock for a shared LLC resource (e.g. the
//   request-in / fwd-out channel). WIDTH requesters raise req. One winner is
//   chosen when the resource is ready. The grant is held until the resource
//   reports done, or until a watchdog timeout. The winner is found with two
//   pri_enc_half instances: one searches the requests masked at or above the
//   RR pointer, the other searches all requests.
//
// PARAMETERS
//   WIDTH      8   number of requesters (>=2, need not be a power of 2)
//   LOG_WIDTH  3   clog2(WIDTH); width of index and pointer
//   TIMEOUT    0   cycles in BUSY before forced release; 0 = watchdog off
//   TO_WIDTH   8   watchdog counter width; requires TIMEOUT < 2**TO_WIDTH
//
// PORTS
//   clk        in   1          clock, all state on rising edge
//   rst        in   1          asynchronous reset, active low
//   req        in   WIDTH      per-requester request level
//   res_ready  in   1          shared resource can accept a new owner
//   done       in   1          1-cycle pulse: owner's transaction complete
//   gnt        out  WIDTH      one-hot grant, registered
//   gnt_idx    out  LOG_WIDTH  index of current owner, registered
//   gnt_valid  out  1          grant active (== |gnt)
//   timeout    out  1          1-cycle pulse: grant revoked by watchdog
//
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0,
//     timeout=0, ptr=0, wdog=0. Outputs drop in the same cycle rst asserts.
//   Arbitration (combinational):
//     - mask = req & ~((1<<ptr)-1)
//     - win  = |mask ? enc(mask) : enc(req), where enc = lowest set index
//   FSM:
//     IDLE: if |req && res_ready -> BUSY.
//       At that edge: gnt=1<<win, gnt_idx=win, gnt_valid=1, wdog=0.
//       Latency: request seen in cycle N -> grant visible in cycle N+1.
//     BUSY: gnt, gnt_idx held stable. req and res_ready are ignored;
//       a requester dropping req does not release the grant.
//       - done=1 -> IDLE: gnt=0, gnt_valid=0, ptr=next(gnt_idx).
//       - else if TIMEOUT!=0 && wdog==TIMEOUT-1 -> IDLE: gnt=0,
//         timeout=1 for one cycle, ptr=next(gnt_idx).
//       - else wdog=wdog+1, saturating at the TO_WIDTH maximum.
//   next(i) = (i==WIDTH-1) ? 0 : i+1. Explicit wrap; no modulo 2**LOG_WIDTH.
//   At least one IDLE cycle separates grants. gnt_idx keeps the last owner
//     after release; it is only meaningful while gnt_valid=1.
//   done and the timeout condition in the same cycle: done wins, timeout=0.
//   done while in IDLE: ignored, ptr unchanged.
//   req=0 or res_ready=0 in IDLE: stay in IDLE, no state change.
//   ptr and gnt_idx never exceed WIDTH-1, even for non-power-of-2 WIDTH.
//   Assertions: $onehot0(gnt); gnt_valid==|gnt; timeout implies state was
//     BUSY in the previous cycle.
//
// TESTING
//   1. req=8'b0000_0101, res_ready=1, ptr=0 -> next cycle gnt=0x01,
//      gnt_idx=0; done -> ptr=1. Next grant: gnt=0x04, gnt_idx=2.
//   2. req=0xFF held, done pulsed 2 cycles after each grant -> gnt_idx
//      runs 0,1,...,7,0; no index repeats before wrap.
//   3. WIDTH=5, req=5'b10001, ptr=4 -> gnt_idx=4; after done, ptr=0 and
//      the next grant is gnt_idx=0.
//   4. TIMEOUT=4, grant to idx 3, no done -> gnt drops exactly 4 cycles
//      after gnt rises, timeout pulses 1 cycle, ptr=4. Repeat with done
//      in that same final cycle -> timeout stays 0.
//   5. Grant to idx 1, then req[1] drops with no done -> gnt stays 0x02
//      until done. res_ready=0 with req=0xFF -> no grant issued.
//   6. rst asserted mid-BUSY -> gnt, gnt_valid=0 the same cycle. After
//      release: ptr=0, and req=0x80 is granted idx 7 one cycle later.

Source files
------------

// File: rtl/llc_rr_arbiter.sv
// rtl/llc_rr_arbiter.sv - round-robin arbiter with grant lock and optional watchdog release
// pri_enc_half returns the lowest set index of its input vector.

module pri_enc_half #(
    parameter int WIDTH     = 8,
    parameter int LOG_WIDTH = 3
) (
    input  logic [WIDTH-1:0]     in_vec,
    output logic [LOG_WIDTH-1:0] idx,
    output logic                 found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx   = LOG_WIDTH'(i);
                found = 1'b1;
            end
        end
    end

endmodule

module llc_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int LOG_WIDTH = 3,
    parameter int TIMEOUT   = 0,
    parameter int TO_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req,
    input  logic                 res_ready,
    input  logic                 done,
    output logic [WIDTH-1:0]     gnt,
    output logic [LOG_WIDTH-1:0] gnt_idx,
    output logic                 gnt_valid,
    output logic                 timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [TO_WIDTH-1:0]  WDOG_LAST = TO_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [LOG_WIDTH-1:0] IDX_LAST  = LOG_WIDTH'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     gnt_q, gnt_d;
    logic [LOG_WIDTH-1:0] gnt_idx_q, gnt_idx_d;
    logic                 gnt_valid_q, gnt_valid_d;
    logic                 timeout_q, timeout_d;
    logic [LOG_WIDTH-1:0] ptr_q, ptr_d;
    logic [TO_WIDTH-1:0]  wdog_q, wdog_d;

    logic [WIDTH-1:0]     mask;
    logic [LOG_WIDTH-1:0] mask_idx, all_idx, win, next_ptr;
    logic                 mask_found, all_found;

    // Requesters at or above the pointer get first chance; otherwise wrap to the lowest.
    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = req[i] && (i >= int'(ptr_q));
        end
    end

    pri_enc_half #(.WIDTH(WIDTH), .LOG_WIDTH(LOG_WIDTH)) u_enc_mask (
        .in_vec (mask),
        .idx    (mask_idx),
        .found  (mask_found)
    );

    pri_enc_half #(.WIDTH(WIDTH), .LOG_WIDTH(LOG_WIDTH)) u_enc_all (
        .in_vec (req),
        .idx    (all_idx),
        .found  (all_found)
    );

    assign win      = mask_found ? mask_idx : all_idx;
    assign next_ptr = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + LOG_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        wdog_d      = wdog_q;
        case (state_q)
            IDLE: begin
                if (all_found && res_ready) begin
                    state_d     = BUSY;
                    gnt_d       = WIDTH'(1) << win;
                    gnt_idx_d   = win;
                    gnt_valid_d = 1'b1;
                    wdog_d      = '0;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = next_ptr;
                end else if (TIMEOUT != 0 && wdog_q == WDOG_LAST) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                    ptr_d       = next_ptr;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + TO_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            wdog_q      <= wdog_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_q));
    a_gnt_valid:  assert property (@(posedge clk) disable iff (!rst) gnt_valid_q == (|gnt_q));
    a_timeout:    assert property (@(posedge clk) disable iff (!rst) timeout_q |-> $past(state_q) == BUSY);

endmodule
